// File: rtl/mem_march_bist.sv
// mem_march_bist: March C- self-test controller in front of a single-port array.
// Idle: host_* pass straight through to mem_*. On start, runs
// E0 up(wZ) E1 up(rZ,wO) E2 up(rO,wZ) E3 dn(rZ,wO) E4 dn(rO,wZ) E5 up(rZ)
// and records the first miscompare plus a saturating miscompare count.
// Optional: define BIST_CHECKERBOARD_EN to repeat the march with 0x55../0xAA..
// backgrounds; this adds the bg_pass output.
module mem_march_bist #(
  parameter int ADDR_BITS    = 5,
  parameter int DATA_BITS    = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_wdata,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [DATA_BITS-1:0] fail_syndrome,
  output logic [7:0]           fail_count
`ifdef BIST_CHECKERBOARD_EN
  ,
  output logic                 bg_pass
`endif
);

`ifdef BIST_CHECKERBOARD_EN
  localparam logic LAST_BG = 1'b1;
`else
  localparam logic LAST_BG = 1'b0;
`endif
  localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           elem_q, elem_d;   // march element 0..5
  logic                 op_q, op_d;       // op slot within the element
  logic [LAT_W-1:0]     lat_q, lat_d;     // cycles spent in the current read
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 bg_q, bg_d;       // 0 = solid, 1 = checkerboard
  logic                 done_q, done_d, fail_q, fail_d;
  logic [ADDR_BITS-1:0] faddr_q, faddr_d;
  logic [DATA_BITS-1:0] fsyn_q, fsyn_d;
  logic [7:0]           fcnt_q, fcnt_d;
`ifdef BIST_CHECKERBOARD_EN
  logic                 fbg_q, fbg_d;
`endif

  logic [DATA_BITS-1:0] bg_z, bg_o, op_data;
  logic op_rd, op_one, op_last, elem_down, rd_last, addr_end, miscmp;

  // Background words: Z is all-zeros, or alternating bits with bit 0 set.
  always_comb begin
    for (int i = 0; i < DATA_BITS; i++) bg_z[i] = bg_q & (i % 2 == 0);
    bg_o = ~bg_z;
  end

  // Decode the current march op from element and slot.
  always_comb begin
    op_rd     = (elem_q == 3'd5) || ((elem_q != 3'd0) && !op_q);
    op_one    = op_rd ? (elem_q == 3'd2 || elem_q == 3'd4)
                      : (elem_q == 3'd1 || elem_q == 3'd3);
    op_last   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    rd_last   = !op_rd || (lat_q == LAT_W'(READ_LATENCY));
    addr_end  = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    op_data   = op_one ? bg_o : bg_z;
    miscmp    = (state_q == S_RUN) && op_rd && rd_last && (mem_rdata != op_data);
  end

  // Sequencer and result capture.
  always_comb begin
    state_d = state_q; elem_d = elem_q; op_d = op_q; lat_d = lat_q;
    addr_d  = addr_q;  bg_d   = bg_q;   done_d = done_q; fail_d = fail_q;
    faddr_d = faddr_q; fsyn_d = fsyn_q; fcnt_d = fcnt_q;
`ifdef BIST_CHECKERBOARD_EN
    fbg_d   = fbg_q;
`endif
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_RUN; elem_d = 3'd0; op_d = 1'b0; lat_d = '0;
        addr_d  = '0;    bg_d   = 1'b0; done_d = 1'b0; fail_d = 1'b0;
        faddr_d = '0;    fsyn_d = '0;   fcnt_d = 8'd0;
`ifdef BIST_CHECKERBOARD_EN
        fbg_d   = 1'b0;
`endif
      end
    end else begin
      if (miscmp) begin
        if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
        if (!fail_q) begin
          fail_d  = 1'b1;
          faddr_d = addr_q;
          fsyn_d  = op_data ^ mem_rdata;
`ifdef BIST_CHECKERBOARD_EN
          fbg_d   = bg_q;
`endif
        end
      end
      if (!rd_last) begin
        lat_d = lat_q + 1'b1;
      end else begin
        lat_d = '0;
        if (!op_last) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!addr_end) begin
            addr_d = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q != 3'd5) begin
            // next element starts at the top only for the two down elements
            elem_d = elem_q + 3'd1;
            addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? ADDR_MAX : '0;
          end else if (bg_q != LAST_BG) begin
            elem_d = 3'd0; addr_d = '0; bg_d = 1'b1;
          end else begin
            state_d = S_IDLE; done_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; elem_q <= 3'd0; op_q <= 1'b0; lat_q <= '0;
      addr_q  <= '0;     bg_q   <= 1'b0; done_q <= 1'b0; fail_q <= 1'b0;
      faddr_q <= '0;     fsyn_q <= '0;   fcnt_q <= 8'd0;
`ifdef BIST_CHECKERBOARD_EN
      fbg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d; elem_q <= elem_d; op_q <= op_d; lat_q <= lat_d;
      addr_q  <= addr_d;  bg_q   <= bg_d;   done_q <= done_d; fail_q <= fail_d;
      faddr_q <= faddr_d; fsyn_q <= fsyn_d; fcnt_q <= fcnt_d;
`ifdef BIST_CHECKERBOARD_EN
      fbg_q   <= fbg_d;
`endif
    end
  end

  assign busy          = (state_q == S_RUN);
  assign mem_we        = busy ? !op_rd  : host_we;
  assign mem_addr      = busy ? addr_q  : host_addr;
  assign mem_wdata     = busy ? op_data : host_wdata;
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = faddr_q;
  assign fail_syndrome = fsyn_q;
  assign fail_count    = fcnt_q;
`ifdef BIST_CHECKERBOARD_EN
  assign bg_pass       = fbg_q;
`endif

endmodule

// File: tb/tb_mem_march_bist.sv
// tb_mem_march_bist: two DUTs (READ_LATENCY 0 and 1) on fault-injectable
// memory models, checked against a table-driven March C- reference.
module tb_mem_march_bist;
  localparam int AW = 5, DW = 8, N = 32;
`ifdef BIST_CHECKERBOARD_EN
  localparam int NBG = 2;
`else
  localparam int NBG = 1;
`endif
  typedef enum int {FK_NONE, FK_STUCK, FK_ALIAS, FK_COUPLE} fk_t;
  typedef logic [AW+DW:0] ent_t;

  logic clk = 0, reset = 1, start = 0, host_we = 0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic we0, we1, busy0, busy1, done0, done1, fail0, fail1;
  logic [AW-1:0] addr0, addr1, faddr0, faddr1;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, syn0, syn1;
  logic [7:0] cnt0, cnt1;
`ifdef BIST_CHECKERBOARD_EN
  logic bgp0, bgp1;
`endif

  always #5 clk = ~clk;

  mem_march_bist #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .mem_we(we0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0), .busy(busy0),
    .done(done0), .fail(fail0), .fail_addr(faddr0), .fail_syndrome(syn0),
    .fail_count(cnt0)
`ifdef BIST_CHECKERBOARD_EN
    , .bg_pass(bgp0)
`endif
  );

  mem_march_bist #(.ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1), .busy(busy1),
    .done(done1), .fail(fail1), .fail_addr(faddr1), .fail_syndrome(syn1),
    .fail_count(cnt1)
`ifdef BIST_CHECKERBOARD_EN
    , .bg_pass(bgp1)
`endif
  );

  // Fault environment shared by the memory models and the reference.
  fk_t fk = FK_NONE;
  logic [AW-1:0] f_addr = '0, f_src = '0;
  int f_bit = 0;

  // Coupling: at f_addr, bit 1 takes the value written to bit 0.
  function automatic logic [DW-1:0] cpl(input logic [DW-1:0] v, input logic [AW-1:0] a);
    if (fk == FK_COUPLE && a == f_addr) v[1] = v[0];
    return v;
  endfunction

  // Stuck-at-1 on bit f_bit of f_addr.
  function automatic logic [DW-1:0] rd_flt(input logic [DW-1:0] v, input logic [AW-1:0] a);
    if (fk == FK_STUCK && a == f_addr) v[f_bit] = 1'b1;
    return v;
  endfunction

  logic [DW-1:0] arr0 [N];
  logic [DW-1:0] arr1 [N];

  assign rdata0 = (fk == FK_STUCK && addr0 == f_addr) ? (arr0[addr0] | (8'h01 << f_bit)) : arr0[addr0];

  // Memory arrays; alias fault: a write to f_src also lands on f_addr.
  always @(posedge clk) begin
    if (we0) begin
      arr0[addr0] <= cpl(wdata0, addr0);
      if (fk == FK_ALIAS && addr0 == f_src) arr0[f_addr] <= cpl(wdata0, f_addr);
    end
    if (we1) begin
      arr1[addr1] <= cpl(wdata1, addr1);
      if (fk == FK_ALIAS && addr1 == f_src) arr1[f_addr] <= cpl(wdata1, f_addr);
    end
    rdata1 <= rd_flt(arr1[addr1], addr1);
  end

  int n_vec = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // March C- table: direction (1 = down) and ops (0 rZ, 1 rO, 2 wZ, 3 wO, -1 none).
  int e_dir [6]    = '{0, 0, 0, 1, 1, 0};
  int e_op  [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};

  ent_t exp0[$], exp1[$], obs0[$], obs1[$];
  logic [DW-1:0] mmem [N];
  int m_cnt, m_bg;
  logic m_fail;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_syn;

  function automatic ent_t ent(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {we, a, we ? d : {DW{1'b0}}};
  endfunction

  // Reference: walk the table over an array, producing the op trace and results.
  task automatic model_run();
    logic [DW-1:0] z, o, d, r;
    logic [AW-1:0] a;
    int op;
    exp0.delete(); exp1.delete();
    m_cnt = 0; m_fail = 0; m_addr = '0; m_syn = '0; m_bg = 0;
    for (int bg = 0; bg < NBG; bg++) begin
      z = (bg == 0) ? {DW{1'b0}} : {(DW/2){2'b01}};
      o = ~z;
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++)
          for (int j = 0; j < 2; j++) begin
            op = e_op[e][j];
            if (op < 0) continue;
            a = AW'(e_dir[e] != 0 ? N - 1 - k : k);
            d = (op == 1 || op == 3) ? o : z;
            if (op >= 2) begin
              mmem[a] = cpl(d, a);
              if (fk == FK_ALIAS && a == f_src) mmem[f_addr] = cpl(d, f_addr);
              exp0.push_back(ent(1'b1, a, d));
              exp1.push_back(ent(1'b1, a, d));
            end else begin
              r = rd_flt(mmem[a], a);
              exp0.push_back(ent(1'b0, a, d));
              exp1.push_back(ent(1'b0, a, d));
              exp1.push_back(ent(1'b0, a, d));
              if (r != d) begin
                if (m_cnt < 255) m_cnt++;
                if (!m_fail) begin m_fail = 1; m_addr = a; m_syn = r ^ d; m_bg = bg; end
              end
            end
          end
    end
  endtask

  function automatic int qdiff(input ent_t a[$], input ent_t b[$]);
    int n = 0;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  task automatic run_march(input string tag);
    int cyc, bad0, bad1;
    model_run();
    obs0.delete(); obs1.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (busy0) obs0.push_back(ent(we0, addr0, wdata0));
      if (busy1) obs1.push_back(ent(we1, addr1, wdata1));
    end while ((busy0 || busy1) && cyc < 1200 * NBG);
    chk({tag, "_timeout"}, 32'(busy0 | busy1), 0);
    chk({tag, "_len0"}, obs0.size(), 320 * NBG);
    chk({tag, "_len1"}, obs1.size(), 480 * NBG);
    chk({tag, "_trace0"}, qdiff(obs0, exp0), 0);
    chk({tag, "_trace1"}, qdiff(obs1, exp1), 0);
    chk({tag, "_done"}, {done0, done1}, 2'b11);
    chk({tag, "_fail0"}, fail0, m_fail);
    chk({tag, "_fail1"}, fail1, m_fail);
    chk({tag, "_faddr0"}, faddr0, m_addr);
    chk({tag, "_faddr1"}, faddr1, m_addr);
    chk({tag, "_syn0"}, syn0, m_syn);
    chk({tag, "_syn1"}, syn1, m_syn);
    chk({tag, "_cnt0"}, cnt0, m_cnt);
    chk({tag, "_cnt1"}, cnt1, m_cnt);
`ifdef BIST_CHECKERBOARD_EN
    chk({tag, "_bg0"}, bgp0, m_bg);
    chk({tag, "_bg1"}, bgp1, m_bg);
`endif
    bad0 = 0; bad1 = 0;
    for (int i = 0; i < N; i++) begin
      if (arr0[i] !== mmem[i]) bad0++;
      if (arr1[i] !== mmem[i]) bad1++;
    end
    chk({tag, "_mem0"}, bad0, 0);
    chk({tag, "_mem1"}, bad1, 0);
  endtask

  initial begin
    // Reset state
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_stat0", {done0, fail0, faddr0, syn0, cnt0}, 0);
    chk("rst_stat1", {done1, fail1, faddr1, syn1, cnt1}, 0);
    chk("rst_we", {we0, we1}, 0);
    reset = 0;

    // Idle pass-through, same cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin host_we = 1; host_addr = 5'h05; host_wdata = 8'hA5; end
      else begin
        host_we = 1'($urandom); host_addr = AW'($urandom); host_wdata = DW'($urandom);
      end
      #1;
      chk("pass0", {we0, addr0, wdata0}, {host_we, host_addr, host_wdata});
      chk("pass1", {we1, addr1, wdata1}, {host_we, host_addr, host_wdata});
    end
    @(negedge clk); host_we = 0;

    fk = FK_NONE;
    run_march("clean");
`ifndef BIST_CHECKERBOARD_EN
    chk("clean_memzero", {arr0[0], arr0[17], arr0[31]}, 0);
`endif

    fk = FK_STUCK; f_addr = 5'h0A; f_bit = 3;
    run_march("sa");
`ifndef BIST_CHECKERBOARD_EN
    chk("sa_spec", {fail0, faddr0, syn0, cnt0}, {1'b1, 5'h0A, 8'h08, 8'd3});
`endif
    for (int i = 0; i < 2; i++) begin
      f_addr = AW'($urandom); f_bit = int'($urandom_range(DW - 1, 0));
      run_march("sa_rnd");
    end

    fk = FK_ALIAS; f_src = 5'h11; f_addr = 5'h01;
    run_march("alias");
    chk("alias_spec", {fail0, faddr0}, {1'b1, 5'h01});
    f_src = AW'($urandom);
    f_addr = f_src ^ AW'($urandom_range(N - 1, 1));
    run_march("alias_rnd");

    fk = FK_COUPLE; f_addr = 5'h03;
    run_march("cpl");
`ifdef BIST_CHECKERBOARD_EN
    chk("cpl_spec", {fail0, bgp0, faddr0}, {1'b1, 1'b1, 5'h03});
`else
    chk("cpl_spec", fail0, 0);
`endif

    // Second start mid-test is ignored; reset mid-test aborts cleanly.
    fk = FK_NONE;
    model_run();
    obs0.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      obs0.push_back(ent(we0, addr0, wdata0));
      if (i == 100) start = 1;
      if (i == 101) start = 0;
      if (i == 150) reset = 1;
    end
    chk("abort_trace", qdiff(obs0, exp0), 0);
    chk("abort_pre_busy", busy0, 1);
    @(negedge clk);
    chk("abort_busy", {busy0, busy1}, 0);
    chk("abort_we", {we0, we1}, 0);
    chk("abort_stat0", {done0, fail0, faddr0, syn0, cnt0}, 0);
    chk("abort_stat1", {done1, fail1, faddr1, syn1, cnt1}, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
